hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and interlock stalls,
// branch flushes and data-memory wait handling, with a saturating stall counter.
//
// state    | meaning
// IDLE     | normal flow; load-use / interlock detected combinationally
// LU_STALL | extra load-use stall cycles, count holds cycles still to stall
// MEM_WAIT | data memory not ready; savedState and count hold the frozen context
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              load_e,
  input  logic              pcsrc_e,
  input  logic              mem_ready_m,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              busy,
  output logic [CNT_W-1:0]  perf_stall_cnt
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  typedef enum logic [1:0] {IDLE, LU_STALL, MEM_WAIT} stateT;

  stateT            state, savedState, effState, nextState, nextSaved;
  logic [CW-1:0]    count, nextCount;
  logic [CNT_W-1:0] perfCnt;
  logic             luHazard, interlock;
  logic             stallFd, stallEm, flushD, flushE;
  logic [1:0]       fwdA, fwdB;

  // x0 is hardwired to zero, so it can never create a dependency
  function automatic logic regMatch(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (FWD_EN != 0) begin
      if (reg_write_m && regMatch(rd_m, rs))
        sel = 2'b10;
      else if (reg_write_w && regMatch(rd_w, rs))
        sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    luHazard  = load_e && (regMatch(rd_e, rs1_d) || regMatch(rd_e, rs2_d));
    interlock = (FWD_EN == 0) &&
                ((reg_write_e && (regMatch(rd_e, rs1_d) || regMatch(rd_e, rs2_d))) ||
                 (reg_write_m && (regMatch(rd_m, rs1_d) || regMatch(rd_m, rs2_d))));
    fwdA      = fwdSel(rs1_e);
    fwdB      = fwdSel(rs2_e);
  end

  // Once memory is ready again, MEM_WAIT acts exactly like the state it interrupted
  assign effState = (state == MEM_WAIT) ? savedState : state;

  always_comb begin
    nextState = state;
    nextSaved = savedState;
    nextCount = count;
    stallFd   = 1'b0;
    stallEm   = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    if (!mem_ready_m) begin
      stallFd   = 1'b1;
      stallEm   = 1'b1;
      nextState = MEM_WAIT;
      if (state != MEM_WAIT)
        nextSaved = state;
    end else if (pcsrc_e) begin
      flushD    = 1'b1;
      flushE    = 1'b1;
      nextState = IDLE;
      nextSaved = IDLE;
      nextCount = '0;
    end else if (effState == LU_STALL) begin
      stallFd   = 1'b1;
      flushE    = 1'b1;
      nextCount = count - CW'(1);
      nextState = (count == CW'(1)) ? IDLE : LU_STALL;
    end else if (luHazard || interlock) begin
      stallFd   = 1'b1;
      flushE    = 1'b1;
      nextState = IDLE;
      if (luHazard && (LOAD_LAT > 1)) begin
        nextState = LU_STALL;
        nextCount = CW'(LOAD_LAT - 1);
      end
    end else begin
      nextState = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      savedState <= IDLE;
      count      <= '0;
      perfCnt    <= '0;
    end else begin
      state      <= nextState;
      savedState <= nextSaved;
      count      <= nextCount;
      if (stallFd && (perfCnt != '1))
        perfCnt <= perfCnt + CNT_W'(1);
    end
  end

  // Everything except the counter is forced quiet while reset is held
  assign forward_ae     = rst ? fwdA : 2'b00;
  assign forward_be     = rst ? fwdB : 2'b00;
  assign stall_f        = rst & stallFd;
  assign stall_d        = rst & stallFd;
  assign stall_e        = rst & stallEm;
  assign stall_m        = rst & stallEm;
  assign flush_d        = rst & flushD;
  assign flush_e        = rst & flushE;
  assign busy           = rst & (state != IDLE);
  assign perf_stall_cnt = perfCnt;

endmodule
